// File: rtl/systolic_drain_pkg.sv
// Shared systolic package: array geometry defaults and the drain FSM encoding.
package systolic_drain_pkg;

    localparam int unsigned DEF_ROWS    = 8;
    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned FRAME_CNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } drain_state_e;

    // Index width for a count of n words; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_drain_frame_transpose.sv
// frame_transpose: combinational word selector over a captured result frame.
//   frame     : ROWS*WIDTH frame, row r at [r*WIDTH +: WIDTH]
//   idx       : word index to select
//   col_major : 0 = return row idx, 1 = return column idx (bit r = row r bit idx)
//   word      : selected WIDTH-bit word
module frame_transpose #(
    parameter int unsigned ROWS  = 8,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [ROWS*WIDTH-1:0] frame,
    input  logic [IDX_W-1:0]      idx,
    input  logic                  col_major,
    output logic [WIDTH-1:0]      word
);

    // Mux-tree selection; constant loop bounds keep every index static.
    always_comb begin
        word = '0;
        if (!col_major) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                if (idx == IDX_W'(r)) begin
                    word = frame[r*WIDTH +: WIDTH];
                end
            end
        end else begin
            // Column bits only exist for rows that fit in the output word.
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < WIDTH; c++) begin
                    if ((r < WIDTH) && (idx == IDX_W'(c))) begin
                        word[r] = frame[r*WIDTH + c];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: captures one result frame from the systolic array and drains
// it word by word (row- or column-major) over a valid/ready stream.
//   clk, rst_n  : clock, synchronous active-low reset
//   ena         : global enable, low freezes all state
//   load        : capture load_data / col_major (honoured only when idle)
//   load_data   : ROWS*WIDTH frame, row r at [r*WIDTH +: WIDTH]
//   col_major   : readout order for the captured frame
//   out_ready   : downstream accepts out_data
//   out_data    : current word (zero when out_valid is low)
//   out_valid   : out_data valid
//   busy        : frame captured and not fully drained
//   word_idx    : index of the word on offer
//   overrun     : sticky, load arrived while busy
//   frame_cnt   : fully drained frames, wrapping
module systolic_drain
    import systolic_drain_pkg::*;
#(
    parameter int unsigned ROWS  = DEF_ROWS,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          load,
    input  logic [ROWS*WIDTH-1:0]         load_data,
    input  logic                          col_major,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    output logic                          busy,
    output logic [idx_width(ROWS)-1:0]    word_idx,
    output logic                          overrun,
    output logic [FRAME_CNT_W-1:0]        frame_cnt
);

    localparam int unsigned IDX_W = idx_width(ROWS);

    drain_state_e             state_q, state_d;
    logic [ROWS*WIDTH-1:0]    buf_q, buf_d;
    logic                     cm_q, cm_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     valid_q, valid_d;
    logic [WIDTH-1:0]         data_q, data_d;
    logic                     overrun_q, overrun_d;
    logic [FRAME_CNT_W-1:0]   fcnt_q, fcnt_d;

    logic                     capture_c;
    logic                     xfer_c;
    logic                     last_c;
    logic [WIDTH-1:0]         word_next_c;

    assign capture_c = ena && load && (state_q == ST_IDLE);
    assign xfer_c    = ena && valid_q && out_ready;
    assign last_c    = (idx_q == IDX_W'(ROWS - 1));

    // Next-state and control decode.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cm_d      = cm_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        fcnt_d    = fcnt_q;
        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        buf_d   = load_data;
                        cm_d    = col_major;
                        idx_d   = '0;
                        valid_d = 1'b1;
                        state_d = ST_SEND;
                    end
                end
                ST_SEND: begin
                    // A load during the final transfer still counts as overrun.
                    if (load) begin
                        overrun_d = 1'b1;
                    end
                    if (xfer_c) begin
                        if (last_c) begin
                            state_d = ST_IDLE;
                            valid_d = 1'b0;
                            idx_d   = '0;
                            fcnt_d  = fcnt_q + FRAME_CNT_W'(1);
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // The next word is looked up from the next-state buffer/index so that
    // out_data can be registered alongside out_valid.
    frame_transpose #(
        .ROWS  (ROWS),
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_transpose (
        .frame     (buf_d),
        .idx       (idx_d),
        .col_major (cm_d),
        .word      (word_next_c)
    );

    // Output word only moves on capture or transfer; zero whenever invalid.
    always_comb begin
        data_d = data_q;
        if (capture_c || xfer_c) begin
            data_d = valid_d ? word_next_c : '0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            buf_q     <= '0;
            cm_q      <= 1'b0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cm_q      <= cm_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = (state_q == ST_SEND);
    assign word_idx  = idx_q;
    assign overrun   = overrun_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain: stimulus pushes expected words, a
// negedge monitor compares every offered word against the queue head.
module tb_systolic_drain;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        load;
    logic [63:0] load_data;
    logic        col_major;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        busy;
    logic [2:0]  word_idx;
    logic        overrun;
    logic [7:0]  frame_cnt;

    logic [7:0]  exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    systolic_drain #(.ROWS(8), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .load      (load),
        .load_data (load_data),
        .col_major (col_major),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .word_idx  (word_idx),
        .overrun   (overrun),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [63:0] w);
        for (int i = 0; i < 8; i++) exp_q.push_back(w[i*8 +: 8]);
    endtask

    task automatic do_load(input logic [63:0] d, input logic cm, input logic [63:0] exp_w, input bit push);
        if (push) push_words(exp_w);
        load      = 1'b1;
        load_data = d;
        col_major = cm;
        tick();
        load      = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        check("drain_timeout", 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Monitor: offered word must equal queue head every valid cycle (covers
    // stalls and ena=0 holds); pop on transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(out_data), 64'hDEAD);
                end else begin
                    check("word", 64'(out_data), 64'(exp_q[0]));
                    if (out_ready && ena) void'(exp_q.pop_front());
                end
            end else begin
                check("idle_zero", 64'(out_data), 64'd0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; load = 1'b0; load_data = '0;
        col_major = 1'b0; out_ready = 1'b1;
        do_reset();
        check("rst_valid",   64'(out_valid), 64'd0);
        check("rst_data",    64'(out_data),  64'd0);
        check("rst_idx",     64'(word_idx),  64'd0);
        check("rst_busy",    64'(busy),      64'd0);
        check("rst_overrun", 64'(overrun),   64'd0);
        check("rst_fcnt",    64'(frame_cnt), 64'd0);

        // Row-major identity, full throughput: 8 words in 8 cycles.
        do_load(64'h8040201008040201, 1'b0, 64'h8040201008040201, 1'b1);
        check("first_valid", 64'(out_valid), 64'd1);
        check("first_idx",   64'(word_idx),  64'd0);
        for (int i = 0; i < 7; i++) tick();
        check("tp_busy7", 64'(busy),     64'd1);
        check("tp_idx7",  64'(word_idx), 64'd7);
        tick();
        check("tp_done",  64'(busy),      64'd0);
        check("fcnt1",    64'(frame_cnt), 64'd1);

        // Column-major identity transposes to itself.
        do_load(64'h8040201008040201, 1'b1, 64'h8040201008040201, 1'b1);
        wait_idle(20);
        check("fcnt2", 64'(frame_cnt), 64'd2);

        // Rows all 0xF0 -> columns 00 x4 then FF x4.
        do_load(64'hF0F0F0F0F0F0F0F0, 1'b1, 64'hFFFFFFFF00000000, 1'b1);
        wait_idle(20);
        check("fcnt3", 64'(frame_cnt), 64'd3);

        // Stalls with out_ready pattern 1,0,0,1.
        do_load(64'h8877665544332211, 1'b0, 64'h8877665544332211, 1'b1);
        begin
            int p = 0;
            while (busy && p < 100) begin
                out_ready = ((p % 4) == 0) || ((p % 4) == 3);
                tick();
                p++;
            end
        end
        out_ready = 1'b1;
        check("stall_done", 64'(busy),      64'd0);
        check("fcnt4",      64'(frame_cnt), 64'd4);

        // Row 0 = 0xFF, others zero -> every column is 0x01.
        do_load(64'h00000000000000FF, 1'b1, 64'h0101010101010101, 1'b1);
        wait_idle(20);
        check("fcnt5", 64'(frame_cnt), 64'd5);

        // Overrun: second load at word 3 is ignored.
        do_load(64'h0807060504030201, 1'b0, 64'h0807060504030201, 1'b1);
        tick(); tick(); tick();
        check("ovr_idx3", 64'(word_idx), 64'd3);
        do_load(64'hFFFFFFFFFFFFFFFF, 1'b1, 64'd0, 1'b0);
        check("ovr_flag", 64'(overrun), 64'd1);
        wait_idle(20);
        check("fcnt6",    64'(frame_cnt), 64'd6);
        check("ovr_sticky", 64'(overrun), 64'd1);

        // Reset at word 5 discards the frame.
        do_load(64'hA1A2A3A4A5A6A7A8, 1'b0, 64'hA1A2A3A4A5A6A7A8, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        check("mid_idx5", 64'(word_idx), 64'd5);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        check("mrst_valid",   64'(out_valid), 64'd0);
        check("mrst_fcnt",    64'(frame_cnt), 64'd0);
        check("mrst_overrun", 64'(overrun),   64'd0);
        check("mrst_idx",     64'(word_idx),  64'd0);
        rst_n = 1'b1;

        // First post-reset load behaves as from power-up.
        do_load(64'h0F0E0D0C0B0A0908, 1'b0, 64'h0F0E0D0C0B0A0908, 1'b1);
        check("prst_valid", 64'(out_valid), 64'd1);
        check("prst_data",  64'(out_data),  64'h08);
        wait_idle(20);
        check("prst_fcnt",  64'(frame_cnt), 64'd1);

        // ena low for 3 cycles at word 2: nothing moves, load ignored.
        do_load(64'h1122334455667788, 1'b0, 64'h1122334455667788, 1'b1);
        tick(); tick();
        ena       = 1'b0;
        load      = 1'b1;
        load_data = 64'hFFFFFFFFFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ena_idx",   64'(word_idx),  64'd2);
            check("ena_data",  64'(out_data),  64'h66);
            check("ena_valid", 64'(out_valid), 64'd1);
        end
        load = 1'b0;
        ena  = 1'b1;
        check("ena_overrun", 64'(overrun), 64'd0);
        wait_idle(20);
        check("ena_fcnt", 64'(frame_cnt), 64'd2);

        // 256 back-to-back frames wrap frame_cnt.
        do_reset();
        for (int f = 0; f < 256; f++) begin
            logic [63:0] d;
            for (int r = 0; r < 8; r++) d[r*8 +: 8] = 8'(f + r);
            do_load(d, 1'b0, d, 1'b1);
            wait_idle(20);
            if (f == 254) check("fcnt255", 64'(frame_cnt), 64'd255);
        end
        check("fcnt_wrap", 64'(frame_cnt), 64'd0);

        tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
